// File: rtl/imm_materializer_if.sv
// Request/instruction-stream bundle for imm_materializer.
// The slave modport is the encoder; the master modport is the producer/consumer side.
interface imm_materializer_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_value;
    logic [4:0]  req_rd;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [1:0]  instr_hw;
    logic        instr_last;

    modport slave (
        input  req_valid, req_value, req_rd, instr_ready,
        output req_ready, instr_valid, instr_word, instr_hw, instr_last
    );
    modport master (
        output req_valid, req_value, req_rd, instr_ready,
        input  req_ready, instr_valid, instr_word, instr_hw, instr_last
    );
endinterface

// File: rtl/imm_materializer.sv
// Turns a 64-bit constant plus Rd into a MOVZ/MOVK instruction stream, one word per handshake.
// Output word is registered; the next pending halfword is precomputed so there are no bubbles.
module imm_materializer #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    imm_materializer_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]  st;
    logic [63:0] value_q;
    logic [4:0]  rd_q;
    logic [3:0]  mask_q;   // halfwords still to emit, excluding the current one
    logic [31:0] word_q;
    logic [1:0]  hw_q;
    logic        last_q;

    logic [3:0]  nz;
    logic [1:0]  first_hw, next_hw;
    logic [3:0]  first_pend, next_pend;

    // {2'b11, opc bit, 6'b100101}: bit 29 distinguishes MOVK (1) from MOVZ (0)
    function automatic logic [31:0] enc(input logic movk, input logic [1:0] hw,
                                        input logic [63:0] v, input logic [4:0] rd);
        enc = {2'b11, movk, 6'b100101, hw, v[{hw, 4'b0000} +: 16], rd};
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      lowest = 2'd0;
        else if (m[1]) lowest = 2'd1;
        else if (m[2]) lowest = 2'd2;
        else if (m[3]) lowest = 2'd3;
        else           lowest = 2'd0;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_nz
        assign nz[i] = |bus.req_value[16*i +: 16];
    end

    // An all-zero value falls out naturally: lowest() gives hw0 and nothing stays pending.
    assign first_hw   = SKIP_ZERO ? lowest(nz) : 2'd0;
    assign first_pend = SKIP_ZERO ? (nz & ~(4'b0001 << first_hw)) : 4'b1110;
    assign next_hw    = lowest(mask_q);
    assign next_pend  = mask_q & ~(4'b0001 << next_hw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            value_q <= '0;
            rd_q    <= '0;
            mask_q  <= '0;
            word_q  <= '0;
            hw_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.req_valid) begin
                        value_q <= bus.req_value;
                        rd_q    <= bus.req_rd;
                        mask_q  <= first_pend;
                        word_q  <= enc(1'b0, first_hw, bus.req_value, bus.req_rd);
                        hw_q    <= first_hw;
                        last_q  <= (first_pend == 4'b0000);
                        st      <= EMIT;
                    end
                end
                default: begin
                    if (bus.instr_ready) begin
                        if (last_q) begin
                            st     <= IDLE;
                            mask_q <= '0;
                            word_q <= '0;
                            hw_q   <= '0;
                            last_q <= 1'b0;
                        end else begin
                            mask_q <= next_pend;
                            word_q <= enc(1'b1, next_hw, value_q, rd_q);
                            hw_q   <= next_hw;
                            last_q <= (next_pend == 4'b0000);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready   = (st == IDLE);
    assign bus.instr_valid = (st == EMIT);
    assign bus.instr_word  = word_q;
    assign bus.instr_hw    = hw_q;
    assign bus.instr_last  = last_q;
endmodule

// File: tb/tb_imm_materializer.sv
// Directed bench for imm_materializer: vector table with free-flowing consumer,
// plus hand sequences for backpressure, mid-sequence reset and SKIP_ZERO=0.
module tb_imm_materializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    imm_materializer_if bus1 ();
    imm_materializer_if bus0 ();

    imm_materializer #(.SKIP_ZERO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    imm_materializer #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0]      value;
        logic [4:0]       rd;
        logic [2:0]       n;
        logic [3:0][31:0] word;
        logic [3:0][1:0]  hw;
        logic [3:0]       last;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready1();
        for (int i = 0; i < 20 && !bus1.req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("req_ready_wait", 64'(bus1.req_ready), 64'd1);
    endtask

    task automatic send1(input logic [63:0] v, input logic [4:0] rd);
        bus1.req_value = v;
        bus1.req_rd    = rd;
        bus1.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
    endtask

    initial begin
        logic [3:0][31:0] ew0;

        vecs[0] = '{64'h0,                   5'd3,  3'd1,
                    {32'h0, 32'h0, 32'h0, 32'hD2800003}, 8'h00, 4'b0001};
        vecs[1] = '{64'h1234,                5'd5,  3'd1,
                    {32'h0, 32'h0, 32'h0, 32'hD2824685}, 8'h00, 4'b0001};
        vecs[2] = '{64'h1234_0000_0000_ABCD, 5'd1,  3'd2,
                    {32'h0, 32'h0, 32'hF2E24681, 32'hD29579A1}, 8'h0C, 4'b0010};
        vecs[3] = '{64'h0000_5678_0000_0000, 5'd31, 3'd1,
                    {32'h0, 32'h0, 32'h0, 32'hD2CACF1F}, 8'h02, 4'b0001};
        vecs[4] = '{64'h0001_0002_0003_0004, 5'd2,  3'd4,
                    {32'hF2E00022, 32'hF2C00042, 32'hF2A00062, 32'hD2800082}, 8'hE4, 4'b1000};

        bus1.req_valid = 1'b0; bus1.req_value = '0; bus1.req_rd = '0; bus1.instr_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_value = '0; bus0.req_rd = '0; bus0.instr_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus1.instr_valid), 64'd0);
        chk("rst_ready", 64'(bus1.req_ready),   64'd1);
        chk("rst_word",  64'(bus1.instr_word),  64'h0);
        chk("rst_last",  64'(bus1.instr_last),  64'd0);
        rst = 1'b0;

        // Table vectors, consumer always ready
        for (int v = 0; v < 5; v++) begin
            wait_ready1();
            send1(vecs[v].value, vecs[v].rd);
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                chk($sformatf("v%0d_valid%0d", v, k), 64'(bus1.instr_valid), 64'd1);
                chk($sformatf("v%0d_word%0d", v, k),  64'(bus1.instr_word), 64'(vecs[v].word[k]));
                chk($sformatf("v%0d_hw%0d", v, k),    64'(bus1.instr_hw),   64'(vecs[v].hw[k]));
                chk($sformatf("v%0d_last%0d", v, k),  64'(bus1.instr_last), 64'(vecs[v].last[k]));
                chk($sformatf("v%0d_rdy%0d", v, k),   64'(bus1.req_ready),  64'd0);
                @(posedge clk);
                #1;
            end
            chk($sformatf("v%0d_done_valid", v), 64'(bus1.instr_valid), 64'd0);
            chk($sformatf("v%0d_done_ready", v), 64'(bus1.req_ready),   64'd1);
        end

        // Backpressure: word held for 3 stalled cycles; requests in EMIT ignored
        bus1.instr_ready = 1'b0;
        send1(64'hFFFF_0000_0000_0000, 5'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_word%0d", c), 64'(bus1.instr_word),  64'hD2FFFFE0);
            chk($sformatf("bp_hw%0d", c),   64'(bus1.instr_hw),    64'd3);
            chk($sformatf("bp_last%0d", c), 64'(bus1.instr_last),  64'd1);
            chk($sformatf("bp_vld%0d", c),  64'(bus1.instr_valid), 64'd1);
            chk($sformatf("bp_rdy%0d", c),  64'(bus1.req_ready),   64'd0);
            bus1.req_value = 64'h1111_2222_3333_4444 + 64'(c);
            bus1.req_valid = (c == 1);
            @(posedge clk);
            #1;
        end
        bus1.req_valid = 1'b0;
        chk("bp_word_after", 64'(bus1.instr_word), 64'hD2FFFFE0);
        bus1.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done_valid", 64'(bus1.instr_valid), 64'd0);
        chk("bp_done_ready", 64'(bus1.req_ready),   64'd1);
        @(posedge clk);
        #1;
        chk("bp_no_restart", 64'(bus1.instr_valid), 64'd0);

        // Asynchronous reset mid-sequence
        bus1.instr_ready = 1'b0;
        send1(64'h1234_0000_0000_ABCD, 5'd1);
        chk("rs_first_word", 64'(bus1.instr_word), 64'hD29579A1);
        #2 rst = 1'b1;
        #1;
        chk("rs_valid", 64'(bus1.instr_valid), 64'd0);
        chk("rs_word",  64'(bus1.instr_word),  64'h0);
        chk("rs_hw",    64'(bus1.instr_hw),    64'd0);
        chk("rs_last",  64'(bus1.instr_last),  64'd0);
        chk("rs_ready", 64'(bus1.req_ready),   64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send1(64'h1234, 5'd5);
        chk("rs_new_word", 64'(bus1.instr_word), 64'hD2824685);
        chk("rs_new_last", 64'(bus1.instr_last), 64'd1);
        bus1.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rs_new_done", 64'(bus1.instr_valid), 64'd0);

        // SKIP_ZERO=0 always emits four words
        ew0 = {32'hF2E00005, 32'hF2C00005, 32'hF2A00005, 32'hD2824685};
        bus0.req_value = 64'h1234;
        bus0.req_rd    = 5'd5;
        bus0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s0_valid%0d", k), 64'(bus0.instr_valid), 64'd1);
            chk($sformatf("s0_word%0d", k),  64'(bus0.instr_word),  64'(ew0[k]));
            chk($sformatf("s0_hw%0d", k),    64'(bus0.instr_hw),    64'(k));
            chk($sformatf("s0_last%0d", k),  64'(bus0.instr_last),  64'(k == 3));
            @(posedge clk);
            #1;
        end
        chk("s0_done_valid", 64'(bus0.instr_valid), 64'd0);
        chk("s0_done_ready", 64'(bus0.req_ready),   64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_materializer.md
Name: imm_materializer

Overview:
- Encoder counterpart to the core's immediate-extraction path: converts a 64-bit constant and a destination register into a stream of MOVZ/MOVK instruction words, emitted one per handshake.
- Bit layout matches exactly the fields the decode/extend stage consumes: hw in [22:21], imm16 in [20:5].
- Sits between the test-program generator/boot loader and instruction memory write port; used to build constant-load sequences for CPU benches.

Parameters:
- SKIP_ZERO, 1, 1 = skip all-zero halfwords after the first instruction; 0 = always emit 4 instructions (hw 0..3).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_value  input  64  constant to materialize.
- req_rd  input  5  destination register Rd.
- instr_valid  output  1  instr_word is valid.
- instr_ready  input  1  consumer accepts instr_word this cycle.
- instr_word  output  32  encoded MOVZ/MOVK word.
- instr_hw  output  2  hw field of the current word.
- instr_last  output  1  current word is the final one of the sequence.

Behaviour:
- Encoding:
  - MOVZ = {9'b110100101, hw[1:0], imm16[15:0], Rd[4:0]}.
  - MOVK = {9'b111100101, hw, imm16, Rd}.
  - imm16 = req_value[16*hw+15 : 16*hw].
- Sequence with SKIP_ZERO=1:
  - First word is MOVZ at the lowest nonzero halfword.
  - Then one MOVK per remaining nonzero halfword, in ascending hw.
  - req_value==0 produces a single MOVZ with hw=0, imm16=0.
  - Sequence length is 1..4.
- Sequence with SKIP_ZERO=0: MOVZ hw0, then MOVK hw1, hw2, hw3, regardless of value.
- States are IDLE and EMIT.
  - IDLE: req_ready=1, instr_valid=0. On req_valid&&req_ready at edge N:
    - Latch value and Rd.
    - Compute the pending-halfword mask.
    - Go to EMIT.
    - instr_valid=1 after edge N with the first word (1-cycle latency, registered output).
  - EMIT: req_ready=0; requests are ignored. instr_word, instr_hw and instr_last are held stable while instr_valid && !instr_ready. On instr_valid&&instr_ready:
    - If instr_last, go to IDLE; instr_valid=0 next cycle.
    - Otherwise, advance to the next pending halfword. Advancing never takes more than 1 cycle, so there are no bubbles.
  - No same-cycle accept of a new request on the final handshake. req_ready rises the cycle after the last word is taken.
- instr_last is 1 exactly when no pending halfword remains above the current one (SKIP_ZERO=1), or when hw==3 (SKIP_ZERO=0).
- Reset (asynchronous, any time including mid-sequence):
  - State goes to IDLE and the in-flight sequence is discarded.
  - instr_valid=0, instr_word=32'h0, instr_hw=0, instr_last=0, req_ready=1.
  - The first request is accepted on the first edge after Reset deasserts.
- Internal value/mask registers reset to 0.
- No X propagation: all outputs are defined in every state.

Test Plan:
- Zero value: req_value=0, Rd=3, instr_ready=1 → one word 0xD2800003, hw=0, last=1; req_ready high again 2 cycles after accept.
- Single low halfword: value 0x0000_0000_0000_1234, Rd=5 → one word 0xD2824685, last=1.
- Sparse value: value 0x1234_0000_0000_ABCD, Rd=1 → 0xD29579A1 (hw0, last=0), then 0xF2E24681 (hw3, last=1) on consecutive cycles.
- Top halfword only, with backpressure: value 0xFFFF_0000_0000_0000, Rd=0, instr_ready low 3 cycles → 0xD2FFFFE0 (hw3, last=1) held stable all 3 cycles; taken on the 4th; req_value changes while in EMIT are ignored.
- SKIP_ZERO=0: value 0x1234, Rd=5 → 0xD2824685, 0xF2A00005, 0xF2C00005, 0xF2E00005; last only on the 4th.
- Reset mid-sequence: start 0x1234_0000_0000_ABCD, assert Reset after the first word → outputs zero immediately (asynchronous), req_ready=1; the next request 0x1234, Rd=5 yields only 0xD2824685.
